// File: rtl/instr_mem_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for instr_mem_loader.
// The master side feeds bytes and starts sessions. The slave side is the loader.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_last;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, byte_in, byte_valid, byte_last,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, overflow, word_count
  );

  modport slave (
    input  start, byte_in, byte_valid, byte_last,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, overflow, word_count
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a big-endian byte stream into instruction words and writes them to
// consecutive memory addresses. A session stops on byte_last or when memory is full.

module instr_byte_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       ld,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= d;
  end
endmodule

module instr_mem_loader #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_mem_loader_if.slave     bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int NUM_LANES = DATA_W / 8;
  localparam int IDX_W     = $clog2(NUM_LANES);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_LANES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [1:0]                  state;
  logic [IDX_W-1:0]            idx;
  logic                        last_q;
  logic [ADDR_W-1:0]           wr_addr;
  logic [ADDR_W:0]             word_count;
  logic                        done_q;
  logic                        ovf_q;
  logic [NUM_LANES-1:0][7:0]   lanes;
  logic [DATA_W-1:0]           word;

  logic sess_open, accept, word_end, wr_more, lane_clr;

  assign sess_open = ((state == S_IDLE) || (state == S_DONE)) && bus.start;
  assign accept    = (state == S_COLLECT) && bus.byte_valid;
  assign word_end  = accept && ((idx == IDX_LAST) || bus.byte_last);
  assign wr_more   = (state == S_WRITE) && !last_q && (wr_addr != ADDR_MAX);
  // Lanes are zeroed before every new word so a short last word pads with 0x00.
  assign lane_clr  = sess_open || wr_more;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    instr_byte_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (lane_clr),
      .ld    (accept && (idx == IDX_W'(i))),
      .d     (bus.byte_in),
      .q     (lanes[i])
    );
  end

  // Lane 0 holds the first byte of the word and lands in the top byte.
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_LANES; i++)
      word[DATA_W-1-8*i -: 8] = lanes[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      last_q     <= 1'b0;
      wr_addr    <= '0;
      word_count <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state      <= S_COLLECT;
            idx        <= '0;
            last_q     <= 1'b0;
            wr_addr    <= '0;
            word_count <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            if (word_end) begin
              state  <= S_WRITE;
              last_q <= bus.byte_last;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_WRITE: begin
          word_count <= word_count + 1'b1;
          // The top address is sticky so an overflowed session reports where it stopped.
          if (wr_addr != ADDR_MAX) wr_addr <= wr_addr + 1'b1;
          if (last_q) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            ovf_q  <= 1'b0;
          end else if (wr_addr == ADDR_MAX) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            ovf_q  <= 1'b1;
          end else begin
            state <= S_COLLECT;
            idx   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready = (state == S_COLLECT);
  assign bus.busy       = (state == S_COLLECT) || (state == S_WRITE);
  assign bus.wr_en      = (state == S_WRITE);
  assign bus.wr_addr    = wr_addr;
  assign bus.wr_data    = word;
  assign bus.done       = done_q;
  assign bus.overflow   = ovf_q;
  assign bus.word_count = word_count;
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter: ADDR_W, 13, instruction memory word-address width.
REQ-002 Parameter: DATA_W, 32, instruction word width; fixed at 4 bytes.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  one-cycle pulse opening a load session.
REQ-006 Port: byte_in  input  8  program byte stream.
REQ-007 Port: byte_valid  input  1  byte_in holds a valid byte.
REQ-008 Port: byte_last  input  1  qualifies byte_in as the final program byte; meaningful only with byte_valid.
REQ-009 Port: byte_ready  output  1  loader accepts byte this cycle.
REQ-010 Port: wr_en  output  1  instruction-memory write strobe.
REQ-011 Port: wr_addr  output  ADDR_W  word address for the write.
REQ-012 Port: wr_data  output  DATA_W  assembled instruction word.
REQ-013 Port: busy  output  1  session in progress.
REQ-014 Port: done  output  1  session finished; held until next start.
REQ-015 Port: overflow  output  1  memory filled before byte_last seen.
REQ-016 Port: word_count  output  ADDR_W+1  words written this session.

Function
REQ-017 Byte accepted only on a rising edge where byte_valid and byte_ready are both 1.
REQ-018 FSM states: IDLE, COLLECT, WRITE, DONE.
REQ-019 IDLE/DONE + start -> COLLECT; clears wr_addr, word_count, done, overflow, byte index, and data shift register.
REQ-020 start in COLLECT or WRITE is ignored.
REQ-021 byte_ready = 1 only in COLLECT; busy = 1 in COLLECT and WRITE.
REQ-022 Byte order big-endian: byte index 0 -> wr_data[31:24], index 3 -> wr_data[7:0].
REQ-023 Byte accepted at index 3, or any index with byte_last = 1 -> WRITE on next edge.
REQ-024 When byte_last arrives at index k < 3, the unfilled low-order bytes are written as 0x00.
REQ-025 WRITE lasts exactly one cycle: wr_en = 1 with stable wr_addr and wr_data, sampled by the memory write port on the next rising clk.
REQ-026 Write latency: wr_en high in the cycle immediately after the completing byte is accepted.
REQ-027 On leaving WRITE, word_count increments by 1.
REQ-028 On leaving WRITE, wr_addr increments by 1, unless wr_addr = 2^ADDR_W-1.
REQ-029 WRITE exit, word was last -> DONE, done = 1, overflow = 0.
REQ-030 WRITE exit, not last, wr_addr = 2^ADDR_W-1 -> DONE with done = 1, overflow = 1, and wr_addr held at 8191 (no wrap).
REQ-031 WRITE exit, otherwise -> COLLECT with byte index 0.
REQ-032 wr_en = 0 in all states except WRITE; no write ever occurs outside a session.
REQ-033 A byte presented during WRITE or DONE is not consumed; a byte held valid across WRITE is accepted exactly once, in the following COLLECT cycle.

Reset
REQ-034 rst_n = 0 forces IDLE immediately, independent of clk.
REQ-035 While rst_n = 0, these outputs are 0: byte_ready, wr_en, wr_addr, wr_data, busy, done, overflow, word_count.
REQ-036 Reset mid-session discards any partial word (no write is issued).
REQ-037 After reset, the next start begins at wr_addr 0.

Verification
REQ-038 Reset: assert rst_n = 0 between edges -> all outputs 0 at once, state IDLE.
REQ-039 start, then bytes 20 08 00 05 with last on the 4th -> single wr_en pulse, wr_addr = 0, wr_data = 0x20080005, then done = 1, word_count = 1.
REQ-040 start, bytes 11 22 33 44 55 66 (last on 66) -> write 0x11223344 @0, then 0x55660000 @1, word_count = 2.
REQ-041 byte_valid held continuously with AA repeated across a WRITE cycle -> byte_ready = 0 during WRITE, and each AA counted once (verified via written data).
REQ-042 8192 full words with no last -> last write @8191, overflow = 1, done = 1, byte_ready = 0, word_count = 8192.
REQ-043 rst_n pulsed low after 2 bytes, then start with 01 02 03 04 last -> no write from the partial word, write 0x01020304 @0.
